word_to_half_serializer: RTL and testbench
==========================================

// Module: word_to_half_serializer
// PURPOSE
//  Inverse of the 16->32 unsigned-extend path: narrows 32-bit datapath words onto a 16-bit bus.
//  Accepts one word over a valid/ready handshake and emits it as 16-bit beats, low half first.
//  Sits between the CPU store/writeback datapath and the 16-bit memory/peripheral bus.
//  With ZX_COMPRESS_EN, a zero-extended halfword is sent as a single tagged beat.
// PARAMETERS
//  HALF_W    16   output beat width; input word width is 2*HALF_W
//  CNT_W     16   width of the sent-word counter
// PORTS
//  clk_i          in   1         clock, all state on rising edge
//  rst_i          in   1         reset, asynchronous, active-high
//  in_valid_i     in   1         upstream word valid
//  in_ready_o     out  1         block can accept a word this cycle
//  in_data_i      in   2*HALF_W  word to narrow
//  out_valid_o    out  1         beat valid
//  out_ready_i    in   1         downstream accepts beat
//  out_data_o     out  HALF_W    beat data
//  out_last_o     out  1         final beat of current word
//  out_zx_o       out  1         beat is a compressed zero-extended word (0 unless ZX_COMPRESS_EN)
//  words_sent_o   out  CNT_W     count of fully sent words, wraps at 2**CNT_W
// BEHAVIOUR
//  - Reset (async, rst_i=1): state=IDLE, out_valid_o=0, out_data_o=0, out_last_o=0,
//    out_zx_o=0, words_sent_o=0, word buffer cleared; in_ready_o=1 once rst_i deasserts.
//  - Handshakes: input xfer = in_valid_i & in_ready_o; output xfer = out_valid_o & out_ready_i.
//  - FSM: IDLE -> LOW on input xfer; LOW -> HIGH on output xfer (two-beat word);
//    LOW -> IDLE/LOW on output xfer when beat is last; HIGH -> IDLE/LOW on output xfer.
//  - in_ready_o = (state==IDLE) | (out_valid_o & out_last_o & out_ready_i) (combinational);
//    word accepted on a last-beat cycle goes straight to LOW: back-to-back, no bubble.
//  - Latency: first beat valid 1 cycle after input xfer (registered); 2 beats/word at full rate.
//  - LOW beat: out_data_o = word[HALF_W-1:0]; HIGH beat: word[2*HALF_W-1:HALF_W], out_last_o=1.
//  - Stall: while out_valid_o & ~out_ready_i, out_data_o/out_last_o/out_zx_o held stable.
//  - out_valid_o never deasserts without an output xfer (no beat withdrawal).
//  - words_sent_o increments by 1 on each output xfer with out_last_o=1; wraps FFFF->0000.
//  - in_valid_i while busy (not last-beat-accepting) is ignored; upstream must hold.
//  - Reset mid-word: partial word discarded, no further beats of it emitted.
// CONFIGURATION
//  Macro ZX_COMPRESS_EN:
//  - defined: on input xfer, if word[2*HALF_W-1:HALF_W]==0 the LOW beat has out_last_o=1,
//    out_zx_o=1, no HIGH beat; receiver re-extends with the unsigned-extend path.
//  - undefined: every word is two beats; out_zx_o tied 0; zero-detect logic absent.
// STRUCTURE
//  - Shared package/header: FSM state encodings (IDLE=2'd0, LOW=2'd1, HIGH=2'd2),
//    default HALF_W, beat-order constant (low-first).
//  - One sub-module natural: upper_zero_detect (HALF_W-input NOR), instantiated only
//    under ZX_COMPRESS_EN. FSM, word buffer and counter stay in top.
// TESTING
//  1 reset then word 0x1234_ABCD, out_ready_i=1 -> beats 0xABCD (last=0), 0x1234 (last=1);
//    words_sent_o=1.
//  2 words 0x0001_0002, 0x0003_0004 back-to-back, ready=1 -> beats 0002,0001,0004,0003 on
//    4 consecutive cycles, in_ready_o high on each last-beat cycle.
//  3 word 0xDEAD_BEEF, out_ready_i low 5 cycles -> 0xBEEF held stable, in_ready_o=0, then
//    beats complete in order after release.
//  4 word 0x0000_8001: with ZX_COMPRESS_EN -> one beat 0x8001, last=1, zx=1;
//    without -> beats 0x8001, 0x0000, zx=0.
//  5 rst_i pulsed after first beat of 0xCAFE_F00D -> out_valid_o=0 asynchronously, 0xCAFE never
//    emitted, words_sent_o=0; next word sent normally.
//  6 force words_sent_o to 0xFFFF via 65535 words (or fast sim) -> next word wraps to 0x0000.

Source files
------------

// File: rtl/word_to_half_serializer_pkg.sv
// Shared definitions for the word-to-halfword serializer: FSM encodings,
// default beat width and beat ordering.
package word_to_half_serializer_pkg;

    localparam int HALF_W_DEF = 16;

    // Low half travels first so the receiver can start re-assembly immediately.
    localparam bit LOW_FIRST = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

endpackage

// File: rtl/word_to_half_serializer_upper_zero_detect.sv
// Flags a halfword that is all zeros; used to spot zero-extended words
// (only instantiated when ZX_COMPRESS_EN is defined).
module word_to_half_serializer_upper_zero_detect #(
    parameter int HALF_W = 16
) (
    input  logic [HALF_W-1:0] i_half,
    output logic              o_zero
);

    assign o_zero = ~(|i_half);

endmodule

// File: rtl/word_to_half_serializer.sv
// Narrows 32-bit words onto a 16-bit beat bus, low half first.
// Optional macro ZX_COMPRESS_EN sends zero-extended words as one tagged beat.
module word_to_half_serializer
    import word_to_half_serializer_pkg::*;
#(
    parameter int HALF_W = HALF_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [2*HALF_W-1:0] in_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [HALF_W-1:0]   out_data_o,
    output logic                out_last_o,
    output logic                out_zx_o,
    output logic [CNT_W-1:0]    words_sent_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t                r_state;
    state_t                w_nextState;
    logic [2*HALF_W-1:0]   r_word;
    logic [HALF_W-1:0]     r_data;
    logic                  r_last;
    logic                  r_zx;
    logic [CNT_W-1:0]      r_count;
    logic                  w_inXfer;
    logic                  w_outXfer;
    logic                  w_upperZero;
    logic [HALF_W-1:0]     w_firstHalf;
    logic [HALF_W-1:0]     w_secondHalf;

`ifdef ZX_COMPRESS_EN
    word_to_half_serializer_upper_zero_detect #(
        .HALF_W (HALF_W)
    ) u_upper_zero_detect (
        .i_half (in_data_i[2*HALF_W-1:HALF_W]),
        .o_zero (w_upperZero)
    );
`else
    assign w_upperZero = 1'b0;
`endif

    assign out_valid_o  = (r_state != ST_IDLE);
    assign out_data_o   = r_data;
    assign out_last_o   = r_last;
    assign out_zx_o     = r_zx;
    assign words_sent_o = r_count;

    // Accepting on the last-beat cycle keeps words flowing with no bubble.
    assign in_ready_o = (r_state == ST_IDLE) | (out_valid_o & out_last_o & out_ready_i);
    assign w_inXfer   = in_valid_i & in_ready_o;
    assign w_outXfer  = out_valid_o & out_ready_i;

    assign w_firstHalf  = LOW_FIRST ? in_data_i[HALF_W-1:0] : in_data_i[2*HALF_W-1:HALF_W];
    assign w_secondHalf = LOW_FIRST ? r_word[2*HALF_W-1:HALF_W] : r_word[HALF_W-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_inXfer) w_nextState = ST_LOW;
            end
            ST_LOW: begin
                if (w_outXfer) begin
                    if (!r_last)       w_nextState = ST_HIGH;
                    else if (w_inXfer) w_nextState = ST_LOW;
                    else               w_nextState = ST_IDLE;
                end
            end
            ST_HIGH: begin
                if (w_outXfer) w_nextState = w_inXfer ? ST_LOW : ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Beat registers only change on a new word or when the current beat is taken,
    // so a stalled beat stays stable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_word <= '0;
            r_data <= '0;
            r_last <= 1'b0;
            r_zx   <= 1'b0;
        end else if (w_inXfer) begin
            r_word <= in_data_i;
            r_data <= w_firstHalf;
            r_last <= w_upperZero;
            r_zx   <= w_upperZero;
        end else if (w_outXfer && !r_last) begin
            r_data <= w_secondHalf;
            r_last <= 1'b1;
            r_zx   <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (w_outXfer && r_last) begin
            r_count <= r_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_word_to_half_serializer.sv
// Directed bench for word_to_half_serializer; expectations follow the
// ZX_COMPRESS_EN setting of the build.
module tb_word_to_half_serializer;

   logic        clk;
   logic        rst;
   logic        inValid;
   logic        inReady;
   logic [31:0] inData;
   logic        outValid;
   logic        outReady;
   logic [15:0] outData;
   logic        outLast;
   logic        outZx;
   logic [15:0] wordsSent;

   // Second instance with a narrow counter so the wrap can be reached quickly.
   logic        wRst;
   logic        wInValid;
   logic        wInReady;
   logic [31:0] wInData;
   logic        wOutValid;
   logic        wOutReady;
   logic [15:0] wOutData;
   logic        wOutLast;
   logic        wOutZx;
   logic [3:0]  wCount;

   int errors = 0;
   int checks = 0;
   int lastSeen = 0;

   word_to_half_serializer #(.HALF_W(16), .CNT_W(16)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .in_valid_i   (inValid),
      .in_ready_o   (inReady),
      .in_data_i    (inData),
      .out_valid_o  (outValid),
      .out_ready_i  (outReady),
      .out_data_o   (outData),
      .out_last_o   (outLast),
      .out_zx_o     (outZx),
      .words_sent_o (wordsSent)
   );

   word_to_half_serializer #(.HALF_W(16), .CNT_W(4)) dutWrap (
      .clk_i        (clk),
      .rst_i        (wRst),
      .in_valid_i   (wInValid),
      .in_ready_o   (wInReady),
      .in_data_i    (wInData),
      .out_valid_o  (wOutValid),
      .out_ready_i  (wOutReady),
      .out_data_o   (wOutData),
      .out_last_o   (wOutLast),
      .out_zx_o     (wOutZx),
      .words_sent_o (wCount)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts it and reports any disagreement.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Advance to the falling edge after the next rising edge.
   task automatic applyStimulus();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkBeat(input string tag, input logic [15:0] data, input logic last, input logic zx);
      checkOutput({tag, "_valid"}, {31'd0, outValid}, 32'd1);
      checkOutput({tag, "_data"},  {16'd0, outData},  {16'd0, data});
      checkOutput({tag, "_last"},  {31'd0, outLast},  {31'd0, last});
      checkOutput({tag, "_zx"},    {31'd0, outZx},    {31'd0, zx});
   endtask

   initial begin
      rst = 1'b1; wRst = 1'b1;
      inValid = 1'b0; inData = '0; outReady = 1'b0;
      wInValid = 1'b0; wInData = '0; wOutReady = 1'b0;
      #2;
      checkOutput("rst_valid", {31'd0, outValid}, 32'd0);
      checkOutput("rst_data",  {16'd0, outData},  32'd0);
      checkOutput("rst_last",  {31'd0, outLast},  32'd0);
      checkOutput("rst_zx",    {31'd0, outZx},    32'd0);
      checkOutput("rst_words", {16'd0, wordsSent}, 32'd0);
      @(negedge clk);
      rst = 1'b0; wRst = 1'b0;
      #1;
      checkOutput("rst_inready", {31'd0, inReady}, 32'd1);

      // Test 1: single word, ready held high.
      inValid = 1'b1; inData = 32'h1234_ABCD; outReady = 1'b1;
      applyStimulus();
      inValid = 1'b0;
      checkBeat("t1_b0", 16'hABCD, 1'b0, 1'b0);
      applyStimulus();
      checkBeat("t1_b1", 16'h1234, 1'b1, 1'b0);
      #1;
      checkOutput("t1_inready_last", {31'd0, inReady}, 32'd1);
      applyStimulus();
      checkOutput("t1_idle",  {31'd0, outValid},  32'd0);
      checkOutput("t1_words", {16'd0, wordsSent}, 32'd1);

      // Test 2: two words back-to-back with no bubble.
      inValid = 1'b1; inData = 32'h0001_0002;
      applyStimulus();
      inData = 32'h0003_0004;
      checkBeat("t2_b0", 16'h0002, 1'b0, 1'b0);
      #1;
      checkOutput("t2_inready_b0", {31'd0, inReady}, 32'd0);
      applyStimulus();
      checkBeat("t2_b1", 16'h0001, 1'b1, 1'b0);
      #1;
      checkOutput("t2_inready_b1", {31'd0, inReady}, 32'd1);
      applyStimulus();
      inValid = 1'b0;
      checkBeat("t2_b2", 16'h0004, 1'b0, 1'b0);
      applyStimulus();
      checkBeat("t2_b3", 16'h0003, 1'b1, 1'b0);
      #1;
      checkOutput("t2_inready_b3", {31'd0, inReady}, 32'd1);
      applyStimulus();
      checkOutput("t2_idle",  {31'd0, outValid},  32'd0);
      checkOutput("t2_words", {16'd0, wordsSent}, 32'd3);

      // Test 3: five-cycle downstream stall on the first beat.
      inValid = 1'b1; inData = 32'hDEAD_BEEF; outReady = 1'b0;
      applyStimulus();
      inValid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checkBeat("t3_stall", 16'hBEEF, 1'b0, 1'b0);
         checkOutput("t3_inready", {31'd0, inReady}, 32'd0);
         applyStimulus();
      end
      outReady = 1'b1;
      checkBeat("t3_b0", 16'hBEEF, 1'b0, 1'b0);
      applyStimulus();
      checkBeat("t3_b1", 16'hDEAD, 1'b1, 1'b0);
      applyStimulus();
      checkOutput("t3_idle",  {31'd0, outValid},  32'd0);
      checkOutput("t3_words", {16'd0, wordsSent}, 32'd4);

      // Test 4: zero upper half.
      inValid = 1'b1; inData = 32'h0000_8001;
      applyStimulus();
      inValid = 1'b0;
`ifdef ZX_COMPRESS_EN
      checkBeat("t4_b0", 16'h8001, 1'b1, 1'b1);
      applyStimulus();
`else
      checkBeat("t4_b0", 16'h8001, 1'b0, 1'b0);
      applyStimulus();
      checkBeat("t4_b1", 16'h0000, 1'b1, 1'b0);
      applyStimulus();
`endif
      checkOutput("t4_idle",  {31'd0, outValid},  32'd0);
      checkOutput("t4_words", {16'd0, wordsSent}, 32'd5);

      // Test 5: reset after the first beat discards the rest of the word.
      inValid = 1'b1; inData = 32'hCAFE_F00D;
      applyStimulus();
      inValid = 1'b0;
      checkBeat("t5_b0", 16'hF00D, 1'b0, 1'b0);
      applyStimulus();
      outReady = 1'b0;
      rst = 1'b1;
      #1;
      checkOutput("t5_async_valid", {31'd0, outValid},  32'd0);
      checkOutput("t5_async_words", {16'd0, wordsSent}, 32'd0);
      applyStimulus();
      rst = 1'b0;
      outReady = 1'b1;
      applyStimulus();
      checkOutput("t5_no_cafe", {31'd0, outValid}, 32'd0);
      inValid = 1'b1; inData = 32'h5555_AAAA;
      applyStimulus();
      inValid = 1'b0;
      checkBeat("t5_n0", 16'hAAAA, 1'b0, 1'b0);
      applyStimulus();
      checkBeat("t5_n1", 16'h5555, 1'b1, 1'b0);
      applyStimulus();
      checkOutput("t5_words", {16'd0, wordsSent}, 32'd1);

      // Test 6: counter wrap on the narrow-counter instance.
      wInValid = 1'b1; wInData = 32'h0007_0003; wOutReady = 1'b1;
      for (int c = 0; c < 200 && lastSeen < 15; c++) begin
         if (wOutValid && wOutLast) begin
            lastSeen++;
            if (lastSeen == 15) wInValid = 1'b0;
         end
         applyStimulus();
      end
      wInValid = 1'b0;
      checkOutput("t6_seen", lastSeen, 32'd15);
      checkOutput("t6_full", {28'd0, wCount}, 32'hF);
      wInValid = 1'b1;
      applyStimulus();
      wInValid = 1'b0;
      applyStimulus();
      applyStimulus();
      checkOutput("t6_wrap", {28'd0, wCount}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
